main_fsm: RTL and testbench

Multi-cycle control state machine for the RV64I core. It sequences fetch, decode, execute, memory and writeback for each instruction from the 7-bit opcode and the memory handshake. It drives the datapath enables and mux selects, and drives the 2-bit `alu_op` that the ALU decoder expands into the 4-bit ALU control.

---
 rtl/control_pkg.sv | 51 +++++
 rtl/main_fsm.sv | 160 ++++++++++++++++
 tb/tb_main_fsm.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the RV64I multi-cycle controller: state enum, opcodes
// and datapath mux/ALU-op selects.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JALR,
    S_JAL,
    S_LUI,
    S_AUIPC,
    S_ILLEGAL
  } t_state;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and the 2-bit ALU op.
module main_fsm
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_op,
  input  logic       i_mem_done,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_update,
  output logic       o_branch,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_op,
  output logic       o_illegal_instr
);

  t_state state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    o_mem_req       = 1'b0;
    o_mem_write     = 1'b0;
    o_adr_src       = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_update     = 1'b0;
    o_branch        = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = SRC_A_PC;
    o_alu_src_b     = SRC_B_RS2;
    o_result_src    = RES_ALUOUT;
    o_alu_op        = ALU_ADD;
    o_illegal_instr = 1'b0;

    case (state)
      S_FETCH: begin
        o_mem_req = 1'b1;
        // PC+4 goes straight from the ALU to the PC in the same cycle the word lands
        if (i_mem_done) begin
          o_ir_write   = 1'b1;
          o_pc_update  = 1'b1;
          o_alu_src_a  = SRC_A_PC;
          o_alu_src_b  = SRC_B_FOUR;
          o_alu_op     = ALU_ADD;
          o_result_src = RES_ALU;
          state_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alu_src_a = SRC_A_OLD_PC;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        case (i_op)
          OP_LOAD, OP_STORE:       state_next = S_MEMADR;
          OP_OP, OP_OP_32:         state_next = S_EXECUTER;
          OP_OP_IMM, OP_OP_IMM_32: state_next = S_EXECUTEI;
          OP_BRANCH:               state_next = S_BRANCH;
          OP_JAL:                  state_next = S_JAL;
          OP_JALR:                 state_next = S_JALR;
          OP_LUI:                  state_next = S_LUI;
          OP_AUIPC:                state_next = S_AUIPC;
          default:                 state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        state_next  = i_op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_mem_req    = 1'b1;
        o_adr_src    = 1'b1;
        o_result_src = RES_ALUOUT;
        if (i_mem_done) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_src = RES_MEM;
        o_reg_write  = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        o_mem_req    = 1'b1;
        o_mem_write  = 1'b1;
        o_adr_src    = 1'b1;
        o_result_src = RES_ALUOUT;
        if (i_mem_done) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_RS2;
        o_alu_op    = {1'b1, i_op[3]};
        state_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = {1'b1, i_op[3]};
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        o_result_src = RES_ALUOUT;
        o_reg_write  = 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a  = SRC_A_RS1;
        o_alu_src_b  = SRC_B_RS2;
        o_alu_op     = ALU_SUB;
        o_result_src = RES_ALUOUT;
        o_branch     = 1'b1;
        state_next   = S_FETCH;
      end
      S_JALR: begin
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        state_next  = S_JAL;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms old PC + 4 for rd
        o_alu_src_a  = SRC_A_OLD_PC;
        o_alu_src_b  = SRC_B_FOUR;
        o_alu_op     = ALU_ADD;
        o_result_src = RES_ALUOUT;
        o_pc_update  = 1'b1;
        state_next   = S_ALUWB;
      end
      S_LUI: begin
        o_alu_src_a = SRC_A_ZERO;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        state_next  = S_ALUWB;
      end
      S_AUIPC: begin
        o_alu_src_a = SRC_A_OLD_PC;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        state_next  = S_ALUWB;
      end
      S_ILLEGAL: begin
        o_illegal_instr = 1'b1;
        state_next      = S_ILLEGAL;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: the driver pushes one hand-derived output
// vector per cycle; a negedge monitor pops and compares.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] i_op;
  logic       i_mem_done;
  logic       o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_update;
  logic       o_branch, o_reg_write, o_illegal_instr;
  logic [1:0] o_alu_src_a, o_alu_src_b, o_result_src, o_alu_op;

  main_fsm dut (
    .clk             (clk),
    .rst             (rst),
    .i_op            (i_op),
    .i_mem_done      (i_mem_done),
    .o_mem_req       (o_mem_req),
    .o_mem_write     (o_mem_write),
    .o_adr_src       (o_adr_src),
    .o_ir_write      (o_ir_write),
    .o_pc_update     (o_pc_update),
    .o_branch        (o_branch),
    .o_reg_write     (o_reg_write),
    .o_alu_src_a     (o_alu_src_a),
    .o_alu_src_b     (o_alu_src_b),
    .o_result_src    (o_result_src),
    .o_alu_op        (o_alu_op),
    .o_illegal_instr (o_illegal_instr)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_write, adr_src, ir_write, pc_update, branch, reg_write, illegal,
  //  src_a, src_b, result_src, alu_op}
  function automatic logic [15:0] v(input logic mr, mw, as, ir, pu, br, rw, il,
                                    input logic [1:0] sa, sb, rs, ao);
    return {mr, mw, as, ir, pu, br, rw, il, sa, sb, rs, ao};
  endfunction

  localparam logic [15:0] F_W    = 16'b1000_0000_00_00_00_00;
  localparam logic [15:0] F_D    = 16'b1001_1000_00_10_10_00;
  localparam logic [15:0] DEC    = 16'b0000_0000_01_01_00_00;
  localparam logic [15:0] MEMADR = 16'b0000_0000_10_01_00_00;
  localparam logic [15:0] MEMRD  = 16'b1010_0000_00_00_00_00;
  localparam logic [15:0] MEMWB  = 16'b0000_0010_00_00_01_00;
  localparam logic [15:0] MEMWR  = 16'b1110_0000_00_00_00_00;
  localparam logic [15:0] ALUWB  = 16'b0000_0010_00_00_00_00;
  localparam logic [15:0] BR     = 16'b0000_0100_10_00_00_01;
  localparam logic [15:0] JALR   = 16'b0000_0000_10_01_00_00;
  localparam logic [15:0] JAL    = 16'b0000_1000_01_10_00_00;
  localparam logic [15:0] LUI    = 16'b0000_0000_11_01_00_00;
  localparam logic [15:0] AUIPC  = 16'b0000_0000_01_01_00_00;
  localparam logic [15:0] ILL    = 16'b0000_0001_00_00_00_00;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  wire [15:0] actual = v(o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_update,
                         o_branch, o_reg_write, o_illegal_instr,
                         o_alu_src_a, o_alu_src_b, o_result_src, o_alu_op);

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      vectors++;
      if (actual !== e) begin
        miscompares++;
        $display("FAIL %s: got %b required %b", n, actual, e);
      end
    end
  end

  task automatic cyc(input logic [6:0] op, input logic done, input logic r,
                     input logic [15:0] e, input string n);
    @(posedge clk);
    #1;
    i_op       = op;
    i_mem_done = done;
    rst        = r;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  function automatic logic [15:0] ex_r(input logic [6:0] op);
    return v(0,0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, {1'b1, op[3]});
  endfunction

  function automatic logic [15:0] ex_i(input logic [6:0] op);
    return v(0,0,0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, {1'b1, op[3]});
  endfunction

  initial begin
    logic [6:0] op;
    rst = 1'b1; i_op = '0; i_mem_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ADDI; first vector is the post-reset state
    op = 7'b0010011;
    cyc(op, 0, 0, F_W,   "reset_fetch");
    cyc(op, 1, 0, F_D,   "addi_fetch");
    cyc(op, 1, 0, DEC,   "addi_decode");
    cyc(op, 0, 0, 16'b0000_0000_10_01_00_10, "addi_execi");
    cyc(op, 1, 0, ALUWB, "addi_aluwb");

    // ADDW with two fetch waits
    op = 7'b0111011;
    cyc(op, 0, 0, F_W,   "addw_fetch_w1");
    cyc(op, 0, 0, F_W,   "addw_fetch_w2");
    cyc(op, 1, 0, F_D,   "addw_fetch");
    cyc(op, 0, 0, DEC,   "addw_decode");
    cyc(op, 0, 0, 16'b0000_0000_10_00_00_11, "addw_execr");
    cyc(op, 0, 0, ALUWB, "addw_aluwb");

    // ADD and ADDIW cover the other alu_op bit
    op = 7'b0110011;
    cyc(op, 1, 0, F_D,      "add_fetch");
    cyc(op, 1, 0, DEC,      "add_decode");
    cyc(op, 1, 0, ex_r(op), "add_execr");
    cyc(op, 1, 0, ALUWB,    "add_aluwb");
    op = 7'b0011011;
    cyc(op, 1, 0, F_D,      "addiw_fetch");
    cyc(op, 1, 0, DEC,      "addiw_decode");
    cyc(op, 1, 0, ex_i(op), "addiw_execi");
    cyc(op, 1, 0, ALUWB,    "addiw_aluwb");

    // LW with three MEMREAD waits
    op = 7'b0000011;
    cyc(op, 1, 0, F_D,    "lw_fetch");
    cyc(op, 0, 0, DEC,    "lw_decode");
    cyc(op, 1, 0, MEMADR, "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(op, 0, 0, MEMRD, "lw_memread_wait");
    cyc(op, 1, 0, MEMRD,  "lw_memread");
    cyc(op, 1, 0, MEMWB,  "lw_memwb");

    // SW, zero waits
    op = 7'b0100011;
    cyc(op, 1, 0, F_D,    "sw_fetch");
    cyc(op, 1, 0, DEC,    "sw_decode");
    cyc(op, 1, 0, MEMADR, "sw_memadr");
    cyc(op, 1, 0, MEMWR,  "sw_memwrite");

    // BEQ
    op = 7'b1100011;
    cyc(op, 1, 0, F_D, "beq_fetch");
    cyc(op, 1, 0, DEC, "beq_decode");
    cyc(op, 1, 0, BR,  "beq_branch");

    // JALR -> JAL -> ALUWB
    op = 7'b1100111;
    cyc(op, 1, 0, F_D,   "jalr_fetch");
    cyc(op, 1, 0, DEC,   "jalr_decode");
    cyc(op, 1, 0, JALR,  "jalr_jalr");
    cyc(op, 1, 0, JAL,   "jalr_jal");
    cyc(op, 1, 0, ALUWB, "jalr_aluwb");

    // JAL, LUI, AUIPC
    op = 7'b1101111;
    cyc(op, 1, 0, F_D,   "jal_fetch");
    cyc(op, 1, 0, DEC,   "jal_decode");
    cyc(op, 1, 0, JAL,   "jal_jal");
    cyc(op, 1, 0, ALUWB, "jal_aluwb");
    op = 7'b0110111;
    cyc(op, 1, 0, F_D,   "lui_fetch");
    cyc(op, 1, 0, DEC,   "lui_decode");
    cyc(op, 1, 0, LUI,   "lui_lui");
    cyc(op, 1, 0, ALUWB, "lui_aluwb");
    op = 7'b0010111;
    cyc(op, 1, 0, F_D,   "auipc_fetch");
    cyc(op, 1, 0, DEC,   "auipc_decode");
    cyc(op, 1, 0, AUIPC, "auipc_auipc");
    cyc(op, 1, 0, ALUWB, "auipc_aluwb");

    // SW waiting in MEMWRITE, aborted by reset
    op = 7'b0100011;
    cyc(op, 1, 0, F_D,    "swrst_fetch");
    cyc(op, 1, 0, DEC,    "swrst_decode");
    cyc(op, 1, 0, MEMADR, "swrst_memadr");
    cyc(op, 0, 0, MEMWR,  "swrst_memwrite_wait");
    cyc(op, 0, 1, MEMWR,  "swrst_memwrite_rst");
    cyc(op, 0, 0, F_W,    "swrst_after_reset");

    // Illegal opcode is sticky until reset
    op = 7'b1111111;
    cyc(op, 1, 0, F_D, "ill_fetch");
    cyc(op, 1, 0, DEC, "ill_decode");
    for (int i = 0; i < 10; i++) cyc(op, 1'(i & 1), 0, ILL, "ill_sticky");
    cyc(op, 1, 1, ILL, "ill_during_rst");
    cyc(op, 0, 0, F_W, "ill_cleared");

    // Normal operation resumes after the illegal-state reset
    op = 7'b0010011;
    cyc(op, 1, 0, F_D,      "post_fetch");
    cyc(op, 1, 0, DEC,      "post_decode");
    cyc(op, 1, 0, ex_i(op), "post_execi");
    cyc(op, 1, 0, ALUWB,    "post_aluwb");
    cyc(op, 0, 0, F_W,      "post_fetch_wait");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
